// File: rtl/tt_um_prbs31_checker.sv
// tt_um_prbs31_checker
// Serial PRBS-31 (x^31 + x^28 + 1) checker. Self-synchronises to the incoming
// stream, declares lock after LOCK_COUNT consecutive correct predictions, then
// counts bit errors against a free-running local reference.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ui_in    [0] data, [1] valid, [2] clear error count, [3] byte select
//   uo_out   selected byte of the 16-bit saturating error count
//   uio_in   unused
//   uio_out  [0] locked, [1] error pulse, [3:2] state, [7:4] zero
//   uio_oe   constant 8'h0F
//   ena      unused
module tt_um_prbs31_checker #(
  parameter int unsigned LOCK_COUNT = 64,
  parameter int unsigned WINDOW     = 128,
  parameter int unsigned LOSS_ERRS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned PW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int unsigned EW = $clog2(LOSS_ERRS + 1);
  localparam int unsigned FW = 5;
  localparam int unsigned CW = 16;

  localparam logic [1:0] S_FILL   = 2'b00;
  localparam logic [1:0] S_VERIFY = 2'b01;
  localparam logic [1:0] S_LOCKED = 2'b10;

  logic          bit_in;
  logic          valid;
  logic          clr;
  logic          sel;

  logic [1:0]    state_q, state_d;
  logic [30:0]   h_q, h_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [PW-1:0] win_pos_q, win_pos_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic          err_pulse_q, err_pulse_d;
  logic          locked_q, locked_d;

  logic          p_c;
  logic          mismatch_c;
  logic [EW-1:0] win_err_inc_c;
  logic [CW-1:0] err_inc_c;
  logic          unused_in;

  assign bit_in = ui_in[0];
  assign valid  = ui_in[1];
  assign clr    = ui_in[2];
  assign sel    = ui_in[3];

  assign unused_in = &{1'b0, ena, uio_in, ui_in[7:4]};

  // Next-bit prediction from the history and the resulting comparison
  assign p_c           = h_q[27] ^ h_q[30];
  assign mismatch_c    = bit_in ^ p_c;
  assign win_err_inc_c = win_err_q + EW'(mismatch_c);
  assign err_inc_c     = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      h_q         <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_pos_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_pos_q   <= win_pos_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_pos_d   = win_pos_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    locked_d    = locked_q;

    if (valid) begin
      case (state_q)
        S_FILL: begin
          h_d = {h_q[29:0], bit_in};
          if (fill_cnt_q == FW'(30)) begin
            state_d     = S_VERIFY;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + FW'(1);
          end
        end

        S_VERIFY: begin
          h_d = {h_q[29:0], bit_in};
          // An all-zero history trivially predicts zeros; never count it
          if ((h_q == '0) || mismatch_c) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == MW'(LOCK_COUNT - 1)) begin
            state_d     = S_LOCKED;
            locked_d    = 1'b1;
            match_cnt_d = '0;
            win_pos_d   = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + MW'(1);
          end
        end

        S_LOCKED: begin
          // Free-running reference: a channel error never enters the history
          h_d = {h_q[29:0], p_c};
          if (mismatch_c) begin
            err_cnt_d   = err_inc_c;
            err_pulse_d = 1'b1;
          end
          // Threshold is checked before the window wrap clears win_err
          if (win_err_inc_c == EW'(LOSS_ERRS)) begin
            state_d    = S_FILL;
            locked_d   = 1'b0;
            h_d        = '0;
            fill_cnt_d = '0;
            win_pos_d  = '0;
            win_err_d  = '0;
          end else if (win_pos_q == PW'(WINDOW - 1)) begin
            win_pos_d = '0;
            win_err_d = '0;
          end else begin
            win_pos_d = win_pos_q + PW'(1);
            win_err_d = win_err_inc_c;
          end
        end

        default: begin
          state_d    = S_FILL;
          locked_d   = 1'b0;
          h_d        = '0;
          fill_cnt_d = '0;
        end
      endcase
    end

    // Clear wins over a same-edge increment
    if (clr) begin
      err_cnt_d = '0;
    end
  end

  assign uo_out  = sel ? err_cnt_q[15:8] : err_cnt_q[7:0];
  assign uio_out = {4'b0000, state_q, err_pulse_q, locked_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_prbs31_checker.sv
// Directed testbench for tt_um_prbs31_checker.
module tb_tt_um_prbs31_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui;
  logic [7:0] ui2;
  logic [7:0] uio_in = 8'h00;
  logic       ena = 1'b1;
  logic [7:0] uo, uio_out, uio_oe;
  logic [7:0] uo2, uio_out2, uio_oe2;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [30:0] gen;

  always #5 clk = ~clk;

  tt_um_prbs31_checker dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui), .uo_out(uo),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .ena(ena)
  );

  tt_um_prbs31_checker #(.LOCK_COUNT(1), .WINDOW(128), .LOSS_ERRS(200)) dut2 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui2), .uo_out(uo2),
    .uio_in(uio_in), .uio_out(uio_out2), .uio_oe(uio_oe2), .ena(ena)
  );

  // Reference generator: output lfsr[30], shift in lfsr[27]^lfsr[30]
  task automatic gen_bit(output logic b);
    b   = gen[30];
    gen = {gen[29:0], gen[27] ^ gen[30]};
  endtask

  task automatic step(input logic d, input logic v, input logic c);
    ui[0] = d; ui[1] = v; ui[2] = c;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic d, input logic v);
    ui2[0] = d; ui2[1] = v; ui2[2] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    ui = 8'h00; ui2 = 8'h00;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ui = 8'h00; ui2 = 8'h00;
    #3;
    n_cmp++; if (uo !== 8'h00) begin n_bad++; $display("FAIL reset_uo: got %h expected 00", uo); end
    n_cmp++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
    n_cmp++; if (uio_oe !== 8'h0F) begin n_bad++; $display("FAIL reset_uio_oe: got %h expected 0f", uio_oe); end
    ui[3] = 1'b1; #1;
    n_cmp++; if (uo !== 8'h00) begin n_bad++; $display("FAIL reset_uo_hi: got %h expected 00", uo); end
    ui[3] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_lock;
    logic b;
    int   pulses = 0;
    gen = 31'd1;
    for (int i = 0; i < 94; i++) begin gen_bit(b); step(b, 1'b1, 1'b0); end
    n_cmp++; if (uio_out[3:0] !== 4'b0100) begin n_bad++; $display("FAIL lock_bit94: got %b expected 0100", uio_out[3:0]); end
    gen_bit(b); step(b, 1'b1, 1'b0);
    n_cmp++; if (uio_out[3:0] !== 4'b1001) begin n_bad++; $display("FAIL lock_bit95: got %b expected 1001", uio_out[3:0]); end
    for (int i = 0; i < 2000; i++) begin gen_bit(b); step(b, 1'b1, 1'b0); pulses += int'(uio_out[1]); end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL clean_pulses: got %0d expected 0", pulses); end
    n_cmp++; if (uo !== 8'h00) begin n_bad++; $display("FAIL clean_cnt_lo: got %h expected 00", uo); end
    ui[3] = 1'b1; #1;
    n_cmp++; if (uo !== 8'h00) begin n_bad++; $display("FAIL clean_cnt_hi: got %h expected 00", uo); end
    ui[3] = 1'b0;
  endtask

  task automatic test_isolated_errors;
    logic b;
    int   pulses = 0;
    for (int e = 0; e < 5; e++) begin
      for (int i = 0; i < 50; i++) begin gen_bit(b); step(b, 1'b1, 1'b0); pulses += int'(uio_out[1]); end
      gen_bit(b); step(~b, 1'b1, 1'b0); pulses += int'(uio_out[1]);
      n_cmp++; if (uio_out[1] !== 1'b1) begin n_bad++; $display("FAIL err_pulse_%0d: got %b expected 1", e, uio_out[1]); end
    end
    for (int i = 0; i < 50; i++) begin gen_bit(b); step(b, 1'b1, 1'b0); pulses += int'(uio_out[1]); end
    n_cmp++; if (pulses !== 5) begin n_bad++; $display("FAIL err_pulse_total: got %0d expected 5", pulses); end
    n_cmp++; if (uo !== 8'h05) begin n_bad++; $display("FAIL err_cnt5: got %h expected 05", uo); end
    n_cmp++; if (uio_out[0] !== 1'b1) begin n_bad++; $display("FAIL err_lock_held: got %b expected 1", uio_out[0]); end
    // Invalid cycles with garbage data must do nothing
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 1'b0, 1'b0);
      n_cmp++; if (uio_out[1] !== 1'b0 || uo !== 8'h05) begin n_bad++; $display("FAIL invalid_freeze: got pulse %b cnt %h expected 0 05", uio_out[1], uo); end
    end
    gen_bit(b); step(b, 1'b1, 1'b1);
    n_cmp++; if (uo !== 8'h00) begin n_bad++; $display("FAIL clear: got %h expected 00", uo); end
    gen_bit(b); step(~b, 1'b1, 1'b1);
    n_cmp++; if (uio_out[1] !== 1'b1 || uo !== 8'h00) begin n_bad++; $display("FAIL clear_vs_err: got pulse %b cnt %h expected 1 00", uio_out[1], uo); end
    gen_bit(b); step(b, 1'b1, 1'b0);
    n_cmp++; if (uio_out[1] !== 1'b0 || uio_out[0] !== 1'b1) begin n_bad++; $display("FAIL pulse_one_cycle: got %b expected pulse 0 locked 1", uio_out[1:0]); end
  endtask

  task automatic test_valid_toggle;
    logic b;
    int   nvalid = 0;
    int   pulses = 0;
    do_reset();
    gen = 31'd1;
    while (nvalid < 94) begin
      if ($urandom_range(0, 1) == 1) begin gen_bit(b); step(b, 1'b1, 1'b0); nvalid++; end
      else step(1'($urandom), 1'b0, 1'b0);
    end
    step(1'($urandom), 1'b0, 1'b0);
    n_cmp++; if (uio_out[0] !== 1'b0) begin n_bad++; $display("FAIL tog_lock94: got %b expected 0", uio_out[0]); end
    gen_bit(b); step(b, 1'b1, 1'b0);
    n_cmp++; if (uio_out[0] !== 1'b1) begin n_bad++; $display("FAIL tog_lock95: got %b expected 1", uio_out[0]); end
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1) begin gen_bit(b); step(b, 1'b1, 1'b0); end
      else step(1'($urandom), 1'b0, 1'b0);
      pulses += int'(uio_out[1]);
    end
    n_cmp++; if (pulses !== 0 || uo !== 8'h00) begin n_bad++; $display("FAIL tog_clean: got pulses %0d cnt %h expected 0 00", pulses, uo); end
  endtask

  task automatic test_all_zero;
    int seen = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin step(1'b0, 1'b1, 1'b0); seen += int'(uio_out[0]); end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL zero_locked: got %0d locked cycles expected 0", seen); end
    n_cmp++; if (uio_out[3:2] !== 2'b01) begin n_bad++; $display("FAIL zero_state: got %b expected 01", uio_out[3:2]); end
  endtask

  task automatic test_lock_loss;
    logic b;
    do_reset();
    gen = 31'd1;
    for (int i = 0; i < 105; i++) begin gen_bit(b); step(b, 1'b1, 1'b0); end
    for (int i = 0; i < 15; i++) begin gen_bit(b); step(~b, 1'b1, 1'b0); end
    n_cmp++; if (uio_out[0] !== 1'b1 || uo !== 8'h0F) begin n_bad++; $display("FAIL loss_15: got locked %b cnt %h expected 1 0f", uio_out[0], uo); end
    gen_bit(b); step(~b, 1'b1, 1'b0);
    n_cmp++; if (uio_out[3:0] !== 4'b0010) begin n_bad++; $display("FAIL loss_16_status: got %b expected 0010", uio_out[3:0]); end
    n_cmp++; if (uo !== 8'h10) begin n_bad++; $display("FAIL loss_16_cnt: got %h expected 10", uo); end
    for (int i = 0; i < 5; i++) begin gen_bit(b); step(b, 1'b1, 1'b0); end
    ui[3] = 1'b1; #1;
    n_cmp++; if (uo !== 8'h00) begin n_bad++; $display("FAIL loss_cnt_hi: got %h expected 00", uo); end
    ui[3] = 1'b0; #1;
    n_cmp++; if (uo !== 8'h10) begin n_bad++; $display("FAIL loss_retained: got %h expected 10", uo); end
  endtask

  task automatic test_async_reset;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (uo !== 8'h00 || uio_out !== 8'h00) begin n_bad++; $display("FAIL async_reset: got uo %h uio %h expected 00 00", uo, uio_out); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    logic b;
    do_reset();
    gen = 31'd1;
    for (int i = 0; i < 32; i++) begin gen_bit(b); step2(b, 1'b1); end
    n_cmp++; if (uio_out2[0] !== 1'b1) begin n_bad++; $display("FAIL sat_lock: got %b expected 1", uio_out2[0]); end
    for (int i = 0; i < 65534; i++) begin gen_bit(b); step2(~b, 1'b1); end
    n_cmp++; if (uo2 !== 8'hFE) begin n_bad++; $display("FAIL sat_fffe_lo: got %h expected fe", uo2); end
    ui2[3] = 1'b1; #1;
    n_cmp++; if (uo2 !== 8'hFF) begin n_bad++; $display("FAIL sat_fffe_hi: got %h expected ff", uo2); end
    ui2[3] = 1'b0;
    gen_bit(b); step2(~b, 1'b1);
    n_cmp++; if (uo2 !== 8'hFF || uio_out2[1] !== 1'b1) begin n_bad++; $display("FAIL sat_ffff: got cnt %h pulse %b expected ff 1", uo2, uio_out2[1]); end
    for (int i = 0; i < 3; i++) begin gen_bit(b); step2(~b, 1'b1); end
    n_cmp++; if (uo2 !== 8'hFF) begin n_bad++; $display("FAIL sat_hold_lo: got %h expected ff", uo2); end
    ui2[3] = 1'b1; #1;
    n_cmp++; if (uo2 !== 8'hFF) begin n_bad++; $display("FAIL sat_hold_hi: got %h expected ff", uo2); end
    ui2[3] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_isolated_errors();
    test_valid_toggle();
    test_all_zero();
    test_lock_loss();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
